inst_fetch: RTL and testbench

//  Instruction fetch stage that sits directly downstream of the PC register.
//  - Issues in-order instruction-bus reads at the current PC.
//  - Buffers returned words, with their addresses, in a DEPTH-entry FIFO.
//  - Presents {instruction, address} to decode.
//  - Flushes on a jump, drops in-flight responses, and raises o_fetch_stall
//    so hazard control can hold the PC.

---
 rtl/inst_fetch.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Brief    : Instruction fetch stage. Issues in-order instruction-bus reads
//             at the current PC. Returned words and their addresses are kept
//             in a small FIFO and presented to decode through an output
//             register. A jump flushes the stage and discards any responses
//             still in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter int          DEPTH   = 2,
  parameter logic [31:0] NOP     = 32'h0000_0013,
  parameter logic [2:0]  HOLD_IF = 3'd2
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [31:0] i_pc_addr,
  input  logic        i_jump_flag,
  input  logic [2:0]  i_hold_flag,
  output logic        o_ibus_req,
  output logic [31:0] o_ibus_addr,
  input  logic        i_ibus_gnt,
  input  logic        i_ibus_rvalid,
  input  logic [31:0] i_ibus_rdata,
  output logic        o_fetch_stall,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_addr
);

  localparam int              c_aw    = $clog2(DEPTH);
  localparam int              c_cw    = c_aw + 1;
  localparam logic [c_cw:0]   c_depth = (c_cw + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_cw-1:0] r_outstanding;
  logic [c_cw-1:0] r_drop;
  logic [c_cw-1:0] r_fifo_cnt;
  logic [c_aw-1:0] r_aq_wr;
  logic [c_aw-1:0] r_aq_rd;
  logic [c_aw-1:0] r_fifo_wr;
  logic [c_aw-1:0] r_fifo_rd;
  logic [31:0]     r_aq        [DEPTH];
  logic [31:0]     r_fifo_inst [DEPTH];
  logic [31:0]     r_fifo_addr [DEPTH];
  logic            r_inst_valid;
  logic [31:0]     r_inst;
  logic [31:0]     r_inst_addr;
  logic            r_armed;

  logic [c_cw:0]   w_inflight;
  logic            w_req;
  logic            w_grant;
  logic            w_rvalid;
  logic            w_drop_rsp;
  logic            w_keep;
  logic            w_fifo_empty;
  logic            w_load;
  logic            w_pop;
  logic            w_push;
  logic [31:0]     w_rsp_addr;
  logic [c_cw-1:0] w_drop_next;

  // Credit: never have more words requested or buffered than the FIFO can hold
  assign w_inflight   = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign w_req        = i_reset_n & (r_state == ST_RUN) & ~i_jump_flag & (w_inflight < c_depth);
  assign w_grant      = w_req & i_ibus_gnt;

  // A response with nothing outstanding (e.g. left over from before reset) is ignored
  assign w_rvalid     = i_ibus_rvalid & (r_outstanding != '0);
  assign w_drop_rsp   = w_rvalid & (r_drop != '0);
  assign w_keep       = w_rvalid & (r_drop == '0) & ~i_jump_flag;
  assign w_rsp_addr   = r_aq[r_aq_rd];

  // Decode consumes the output register whenever it is not held
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_load       = ~r_inst_valid | (i_hold_flag < HOLD_IF);
  assign w_pop        = w_load & ~w_fifo_empty;
  // When the FIFO is empty and the output can load, the response bypasses the FIFO
  assign w_push       = w_keep & ~(w_load & w_fifo_empty);

  // Everything still outstanding after this cycle's response must be discarded
  assign w_drop_next  = r_outstanding - c_cw'(w_rvalid);

  assign o_ibus_req    = w_req;
  assign o_ibus_addr   = i_pc_addr;
  assign o_fetch_stall = ~i_jump_flag & ~w_grant;
  assign o_inst_valid  = r_inst_valid;
  assign o_inst        = r_inst;
  assign o_inst_addr   = r_inst_addr;

  // Control state, flush FSM, queue pointers and the decode output register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_RUN;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fifo_cnt    <= '0;
      r_aq_wr       <= '0;
      r_aq_rd       <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      r_inst_valid  <= 1'b0;
      r_inst        <= NOP;
      r_inst_addr   <= '0;
      r_armed       <= 1'b0;
    end else begin
      r_armed       <= 1'b1;
      r_outstanding <= r_outstanding + c_cw'(w_grant) - c_cw'(w_rvalid);
      if (w_grant)  r_aq_wr <= r_aq_wr + c_aw'(1);
      if (w_rvalid) r_aq_rd <= r_aq_rd + c_aw'(1);

      if (i_jump_flag) begin
        r_drop       <= w_drop_next;
        r_state      <= (w_drop_next != '0) ? ST_FLUSH : ST_RUN;
        r_fifo_cnt   <= '0;
        r_fifo_wr    <= '0;
        r_fifo_rd    <= '0;
        r_inst_valid <= 1'b0;
        r_inst       <= NOP;
      end else begin
        if (w_drop_rsp) begin
          r_drop <= r_drop - c_cw'(1);
          if (r_drop == c_cw'(1)) r_state <= ST_RUN;
        end
        if (w_push) r_fifo_wr <= r_fifo_wr + c_aw'(1);
        if (w_pop)  r_fifo_rd <= r_fifo_rd + c_aw'(1);
        r_fifo_cnt <= r_fifo_cnt + c_cw'(w_push) - c_cw'(w_pop);
        if (w_load) begin
          if (!w_fifo_empty) begin
            r_inst_valid <= 1'b1;
            r_inst       <= r_fifo_inst[r_fifo_rd];
            r_inst_addr  <= r_fifo_addr[r_fifo_rd];
          end else if (w_keep) begin
            r_inst_valid <= 1'b1;
            r_inst       <= i_ibus_rdata;
            r_inst_addr  <= w_rsp_addr;
          end else begin
            r_inst_valid <= 1'b0;
            r_inst       <= NOP;
          end
        end
      end
    end
  end

  // Storage for request addresses and buffered instruction words
  always_ff @(posedge i_clock) begin
    if (w_grant) r_aq[r_aq_wr] <= i_pc_addr;
    if (w_push) begin
      r_fifo_inst[r_fifo_wr] <= i_ibus_rdata;
      r_fifo_addr[r_fifo_wr] <= w_rsp_addr;
    end
  end

  // The bus must never return data that was not requested (ignored for one cycle after reset)
  a_rvalid_orphan: assert property (@(posedge i_clock) disable iff (!i_reset_n)
    r_armed |-> !(i_ibus_rvalid && r_outstanding == '0));

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch
//  Brief    : Self-checking bench for inst_fetch: per-cycle control vectors
//             plus a scoreboard of fetched {address, word} pairs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [2:0]  HOLD_IF = 3'd2;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_pc_addr;
  logic        i_jump_flag;
  logic [2:0]  i_hold_flag;
  logic        o_ibus_req;
  logic [31:0] o_ibus_addr;
  logic        i_ibus_gnt;
  logic        i_ibus_rvalid;
  logic [31:0] i_ibus_rdata;
  logic        o_fetch_stall;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_addr;

  always #5 i_clock = ~i_clock;

  inst_fetch #(.DEPTH(2), .NOP(NOP), .HOLD_IF(HOLD_IF)) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_pc_addr     (i_pc_addr),
    .i_jump_flag   (i_jump_flag),
    .i_hold_flag   (i_hold_flag),
    .o_ibus_req    (o_ibus_req),
    .o_ibus_addr   (o_ibus_addr),
    .i_ibus_gnt    (i_ibus_gnt),
    .i_ibus_rvalid (i_ibus_rvalid),
    .i_ibus_rdata  (i_ibus_rdata),
    .o_fetch_stall (o_fetch_stall),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_addr   (o_inst_addr)
  );

  typedef struct {
    bit          gnt;
    bit          rsp;
    bit          late;
    logic [2:0]  hold;
    bit          jump;
    logic [31:0] tgt;
    bit          chk;
    bit          e_req;
    bit          e_stall;
    bit          e_valid;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] pc;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];
  vec_t        tbl[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h00A0_0093 ^ (a << 8);
  endfunction

  function automatic vec_t r(input bit gnt, input bit rsp, input logic [2:0] hold,
                             input bit jump, input logic [31:0] tgt,
                             input bit er, input bit es, input bit ev);
    vec_t v;
    v.gnt = gnt; v.rsp = rsp; v.late = 1'b0; v.hold = hold; v.jump = jump; v.tgt = tgt;
    v.chk = 1'b1; v.e_req = er; v.e_stall = es; v.e_valid = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, advance the PC model
  task automatic run_row(input vec_t v, input string tag);
    logic [31:0] a;
    bit          granted;
    i_ibus_gnt  = v.gnt;
    i_hold_flag = v.hold;
    i_jump_flag = v.jump;
    i_pc_addr   = pc;
    if (v.rsp && pend.size() > 0) begin
      i_ibus_rvalid = 1'b1;
      i_ibus_rdata  = mem(pend.pop_front());
    end else if (v.late) begin
      i_ibus_rvalid = 1'b1;
      i_ibus_rdata  = 32'hDEAD_BEEF;
    end else begin
      i_ibus_rvalid = 1'b0;
      i_ibus_rdata  = '0;
    end
    @(negedge i_clock);
    if (v.chk) begin
      check({tag, " req"},   32'(o_ibus_req),    32'(v.e_req));
      check({tag, " stall"}, 32'(o_fetch_stall), 32'(v.e_stall));
      check({tag, " valid"}, 32'(o_inst_valid),  32'(v.e_valid));
    end
    if (o_ibus_req) check({tag, " ibus_addr"}, o_ibus_addr, pc);
    if (!v.jump && o_inst_valid && v.hold < HOLD_IF) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s inst: got unexpected addr %h, want none", tag, o_inst_addr);
      end else begin
        a = exp_q.pop_front();
        check({tag, " inst_addr"}, o_inst_addr, a);
        check({tag, " inst"},      o_inst,      mem(a));
      end
    end
    if (v.jump) exp_q.delete();
    granted = o_ibus_req && v.gnt;
    if (granted) begin
      pend.push_back(pc);
      exp_q.push_back(pc);
    end
    @(posedge i_clock);
    #1;
    if (v.jump)       pc = v.tgt;
    else if (granted) pc = pc + 32'd4;
  endtask

  initial begin
    vec_t v;
    pc            = '0;
    i_reset_n     = 1'b0;
    i_pc_addr     = '0;
    i_jump_flag   = 1'b0;
    i_hold_flag   = '0;
    i_ibus_gnt    = 1'b0;
    i_ibus_rvalid = 1'b0;
    i_ibus_rdata  = '0;

    repeat (2) @(posedge i_clock);
    #1;
    check("reset valid", 32'(o_inst_valid), 32'd0);
    check("reset inst",  o_inst,            NOP);
    check("reset addr",  o_inst_addr,       32'd0);
    check("reset req",   32'(o_ibus_req),   32'd0);
    i_reset_n = 1'b1;

    //                gnt rsp hold jmp tgt          req stall valid
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 0)); // R0  first request at pc 0
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 0)); // R1
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 1)); // R2  addr 0 valid two cycles after grant
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 1)); // R3
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 1)); // R4  no grant at pc 0x10
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 1)); // R5
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 0)); // R6
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 0)); // R7  stream 0x10,0x14,0x18
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 0)); // R8
    tbl.push_back(r(1, 1, 3'd2, 0, 32'h0,   1, 0, 1)); // R9  hold at HOLD_IF
    tbl.push_back(r(1, 1, 3'd2, 0, 32'h0,   0, 1, 1)); // R10 credit exhausted
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   0, 1, 1)); // R11 release
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 1)); // R12
    tbl.push_back(r(1, 1, 3'd0, 1, 32'h20,  0, 0, 1)); // R13 jump + rvalid + decode pop
    tbl.push_back(r(1, 0, 3'd0, 0, 32'h0,   1, 0, 0)); // R14 request 0x20
    tbl.push_back(r(1, 0, 3'd0, 0, 32'h0,   1, 0, 0)); // R15 request 0x24
    tbl.push_back(r(1, 0, 3'd0, 1, 32'h100, 0, 0, 0)); // R16 jump with two outstanding
    tbl.push_back(r(1, 0, 3'd0, 0, 32'h0,   0, 1, 0)); // R17 flushing
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   0, 1, 0)); // R18 drop 0x20
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   0, 1, 0)); // R19 drop 0x24
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 0)); // R20 request 0x100
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 0)); // R21
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 1)); // R22 0x100 emitted
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 1)); // R23
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 0)); // R24
    tbl.push_back(r(1, 0, 3'd0, 0, 32'h0,   1, 0, 0)); // R25
    tbl.push_back(r(1, 0, 3'd0, 0, 32'h0,   1, 0, 0)); // R26
    tbl.push_back(r(1, 0, 3'd0, 1, 32'h200, 0, 0, 0)); // R27 jump, drop 2
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   0, 1, 0)); // R28 drop one
    tbl.push_back(r(1, 0, 3'd0, 1, 32'h300, 0, 0, 0)); // R29 re-flush while flushing
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   0, 1, 0)); // R30 last drop
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 0)); // R31 request 0x300
    tbl.push_back(r(1, 1, 3'd0, 0, 32'h0,   1, 0, 0)); // R32
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 1)); // R33 0x300 emitted
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 1)); // R34
    tbl.push_back(r(0, 1, 3'd0, 0, 32'h0,   1, 1, 0)); // R35

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Stream a few words, then reset asynchronously between clock edges
    for (int i = 0; i < 3; i++) begin
      v = r(1, 1, 3'd0, 0, 32'h0, 0, 0, 0);
      v.chk = 1'b0;
      run_row(v, $sformatf("stream%0d", i));
    end
    i_ibus_gnt    = 1'b0;
    i_ibus_rvalid = 1'b0;
    #2;
    check("pre-reset valid", 32'(o_inst_valid), 32'd1);
    i_reset_n = 1'b0;
    #1;
    check("async reset valid", 32'(o_inst_valid), 32'd0);
    check("async reset inst",  o_inst,            NOP);
    check("async reset addr",  o_inst_addr,       32'd0);
    check("async reset req",   32'(o_ibus_req),   32'd0);
    pend.delete();
    exp_q.delete();
    pc = '0;
    @(posedge i_clock);
    #1;
    i_reset_n = 1'b1;

    v = r(1, 1, 3'd0, 0, 32'h0, 1, 0, 0);
    v.late = 1'b1;
    run_row(v, "post0");                                  // stale rvalid ignored
    run_row(r(1, 1, 3'd0, 0, 32'h0, 1, 0, 0), "post1");
    run_row(r(0, 1, 3'd0, 0, 32'h0, 1, 1, 1), "post2");   // restart at addr 0
    run_row(r(0, 1, 3'd0, 0, 32'h0, 1, 1, 1), "post3");
    run_row(r(0, 1, 3'd0, 0, 32'h0, 1, 1, 0), "post4");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
